// File: rtl/text_console_pkg.sv
// Shared constants, control codes and state encoding for the text console writer.
`default_nettype none

package text_console_pkg;

    localparam int DEF_COLS = 100;
    localparam int DEF_ROWS = 30;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

    // Low byte of every blank cell; the attribute fills the high byte.
    localparam logic [7:0] BLANK_LOW = CH_SPACE;

    function automatic logic [15:0] blank_word(input logic [7:0] attr);
        return {attr, BLANK_LOW};
    endfunction

endpackage

`default_nettype wire

// File: rtl/text_cursor.sv
// Cursor position tracker: column, row and running line_base (row*COLS without a multiplier).
`default_nettype none

module text_cursor
    import text_console_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        home,
    input  logic        row_adv,
    input  logic        col_inc,
    input  logic        col_dec,
    input  logic        col_load,
    input  logic [6:0]  col_val,
    output logic [6:0]  col,
    output logic [4:0]  row,
    output logic [11:0] line_base,
    output logic [11:0] next_base
);

    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [11:0] COLS_W   = 12'(COLS);

    assign next_base = (row == LAST_ROW) ? 12'd0 : line_base + COLS_W;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
        end else if (home) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
        end else if (row_adv) begin
            col       <= '0;
            row       <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
            line_base <= next_base;
        end else if (col_load) begin
            col <= col_val;
        end else if (col_inc) begin
            col <= col + 7'd1;
        end else if (col_dec) begin
            col <= col - 7'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/text_console_writer.sv
// Byte-stream to text-RAM writer with cursor tracking and line/screen clears.
// Optional TAB handling is enabled by defining TEXT_CONSOLE_TAB_EN.
`default_nettype none

module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS           = DEF_COLS,
    parameter int         ROWS           = DEF_ROWS,
    parameter logic [7:0] BLANK_ATTR     = 8'h0F,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_attr,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic        ram_ce,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);
    localparam logic [11:0] COLS_M1     = 12'(COLS - 1);
    localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);

    state_t      state, state_d;
    logic [11:0] clr_addr, clr_addr_d;
    logic [11:0] clr_end, clr_end_d;
    logic [7:0]  clr_attr, clr_attr_d;
    logic        init_pending, init_d;
    logic        ram_ce_d;
    logic [11:0] ram_addr_d;
    logic [15:0] ram_data_d;

    logic        cur_home, cur_adv, cur_inc, cur_dec, cur_load;
    logic [6:0]  cur_val;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [11:0] line_base, next_base;

    logic        go_line, go_screen;
    logic [7:0]  go_attr;
    logic        is_print;
    logic [11:0] wr_addr;
`ifdef TEXT_CONSOLE_TAB_EN
    logic [7:0]  tab_target;
    assign tab_target = {1'b0, col[6:3], 3'b000} + 8'd8;
`endif

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .home      (cur_home),
        .row_adv   (cur_adv),
        .col_inc   (cur_inc),
        .col_dec   (cur_dec),
        .col_load  (cur_load),
        .col_val   (cur_val),
        .col       (col),
        .row       (row),
        .line_base (line_base),
        .next_base (next_base)
    );

    assign cursor_col = col;
    assign cursor_row = row;
    assign busy       = (state != IDLE);
    // The pending power-on clear must win over incoming bytes.
    assign char_ready = (state == IDLE) && !clear_req && !init_pending;
    assign is_print   = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign wr_addr    = line_base + 12'(col);

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            clr_addr     <= '0;
            clr_end      <= '0;
            clr_attr     <= '0;
            init_pending <= CLEAR_ON_RESET;
            ram_ce       <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
        end else begin
            state        <= state_d;
            clr_addr     <= clr_addr_d;
            clr_end      <= clr_end_d;
            clr_attr     <= clr_attr_d;
            init_pending <= init_d;
            ram_ce       <= ram_ce_d;
            ram_addr     <= ram_addr_d;
            ram_data     <= ram_data_d;
        end
    end

    always_comb begin
        state_d    = state;
        clr_addr_d = clr_addr;
        clr_end_d  = clr_end;
        clr_attr_d = clr_attr;
        init_d     = init_pending;
        ram_ce_d   = 1'b0;
        ram_addr_d = ram_addr;
        ram_data_d = ram_data;
        cur_home   = 1'b0;
        cur_adv    = 1'b0;
        cur_inc    = 1'b0;
        cur_dec    = 1'b0;
        cur_load   = 1'b0;
        cur_val    = '0;
        go_line    = 1'b0;
        go_screen  = 1'b0;
        go_attr    = char_attr;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    go_screen = 1'b1;
                    init_d    = 1'b0;
                end else if (init_pending) begin
                    go_screen = 1'b1;
                    go_attr   = BLANK_ATTR;
                    init_d    = 1'b0;
                end else if (char_valid) begin
                    if (is_print) begin
                        ram_ce_d   = 1'b1;
                        ram_addr_d = wr_addr;
                        ram_data_d = {char_attr, 1'b0, char_data[6:0]};
                        if (col == LAST_COL) begin
                            cur_adv = 1'b1;
                            go_line = 1'b1;
                        end else begin
                            cur_inc = 1'b1;
                        end
                    end else begin
                        case (char_data)
                            CH_LF: begin
                                cur_adv = 1'b1;
                                go_line = 1'b1;
                            end
                            CH_CR: cur_load = 1'b1;
                            CH_BS: begin
                                if (col != 7'd0) begin
                                    cur_dec    = 1'b1;
                                    ram_ce_d   = 1'b1;
                                    ram_addr_d = wr_addr - 12'd1;
                                    ram_data_d = blank_word(char_attr);
                                end
                            end
                            CH_FF: go_screen = 1'b1;
`ifdef TEXT_CONSOLE_TAB_EN
                            CH_TAB: begin
                                if (tab_target >= 8'(COLS)) begin
                                    cur_adv = 1'b1;
                                    go_line = 1'b1;
                                end else begin
                                    cur_load = 1'b1;
                                    cur_val  = tab_target[6:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            CLR_LINE: begin
                if (clear_req) begin
                    go_screen = 1'b1;
                end else begin
                    ram_ce_d   = 1'b1;
                    ram_addr_d = clr_addr;
                    ram_data_d = blank_word(clr_attr);
                    if (clr_addr == clr_end) state_d = IDLE;
                    else clr_addr_d = clr_addr + 12'd1;
                end
            end
            CLR_SCREEN: begin
                ram_ce_d   = 1'b1;
                ram_addr_d = clr_addr;
                ram_data_d = blank_word(clr_attr);
                if (clr_addr == clr_end) begin
                    state_d  = IDLE;
                    cur_home = 1'b1;
                end else begin
                    clr_addr_d = clr_addr + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_screen) begin
            state_d    = CLR_SCREEN;
            clr_addr_d = '0;
            clr_end_d  = SCREEN_LAST;
            clr_attr_d = go_attr;
        end else if (go_line) begin
            state_d    = CLR_LINE;
            clr_addr_d = next_base;
            clr_end_d  = next_base + COLS_M1;
            clr_attr_d = char_attr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected RAM writes are queued, a monitor pops and compares.
`default_nettype none

module tb_text_console_writer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic [7:0]  char_attr = 8'h00;
    logic        clear_req = 1'b0;
    logic        char_ready, busy, ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int tests = 0;
    int fails = 0;
    logic [27:0] exp_q[$];

    text_console_writer dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_attr  (char_attr),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .busy       (busy),
        .ram_ce     (ram_ce),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    always @(negedge clk_sys) begin
        if (reset && ram_ce) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_data);
            end else begin
                check("ram_write", {4'h0, ram_addr, ram_data}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        int n = 0;
        @(negedge clk_sys);
        while (!char_ready && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        if (!char_ready) check("send_ready_timeout", 32'(char_ready), 32'd1);
        char_valid = 1'b1;
        char_data  = d;
        char_attr  = a;
        @(posedge clk_sys);
        #1 char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_sys);
        while (busy && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic lf(input logic [7:0] a, input int new_row);
        for (int j = 0; j < 100; j++) push(12'(new_row * 100 + j), {a, 8'h20});
        send(8'h0A, a);
        wait_idle();
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] ch;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_ram_ce", 32'(ram_ce), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);

        // Power-on clear
        for (int i = 0; i < 3000; i++) push(12'(i), 16'h0F20);
        reset = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        check("por_busy_seen", 32'(busy), 32'd1);
        bad = 0;
        n = 0;
        while (busy && n < 4000) begin
            if (char_ready) bad++;
            @(negedge clk_sys);
            n++;
        end
        check("por_ready_low", 32'(bad), 32'd0);
        check("por_done", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_sys);
        check("por_queue_empty", 32'(exp_q.size()), 32'd0);
        check("por_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
        check("por_ready_high", 32'(char_ready), 32'd1);

        // "AB" back to back
        push(12'd0, 16'h1E41);
        push(12'd1, 16'h1E42);
        char_valid = 1'b1;
        char_data  = 8'h41;
        char_attr  = 8'h1E;
        @(posedge clk_sys);
        #1 char_data = 8'h42;
        @(negedge clk_sys);
        check("ab_first_ce", {19'd0, ram_ce, ram_addr}, {19'd0, 1'b1, 12'd0});
        @(posedge clk_sys);
        #1 char_valid = 1'b0;
        @(negedge clk_sys);
        check("ab_second_ce", {19'd0, ram_ce, ram_addr}, {19'd0, 1'b1, 12'd1});
        check("ab_col", 32'(cursor_col), 32'd2);

        // Move to (5,2), then LF
        lf(8'h07, 1);
        lf(8'h07, 2);
        check("lf_cursor_row2", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd2, 7'd0});
        for (int i = 0; i < 5; i++) begin
            ch = 8'h61 + 8'(i);
            push(12'(200 + i), {8'h07, 1'b0, ch[6:0]});
            send(ch, 8'h07);
        end
        check("pre_lf_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd2, 7'd5});
        for (int j = 0; j < 100; j++) push(12'(300 + j), 16'h0720);
        send(8'h0A, 8'h07);
        check("lf_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd3, 7'd0});
        n = 0;
        @(negedge clk_sys);
        while (!char_ready && n < 200) begin
            n++;
            @(negedge clk_sys);
        end
        check("lf_ready_low_cycles", 32'(n), 32'd100);
        repeat (2) @(negedge clk_sys);
        check("lf_queue_empty", 32'(exp_q.size()), 32'd0);

        // Walk to (99,29) and wrap
        for (int r = 4; r <= 29; r++) lf(8'h07, r);
        for (int i = 0; i < 99; i++) begin
            ch = 8'h41 + 8'(i % 26);
            push(12'(2900 + i), {8'h07, 1'b0, ch[6:0]});
            send(ch, 8'h07);
        end
        check("edge_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd29, 7'd99});
        push(12'd2999, 16'h1E78);
        for (int j = 0; j < 100; j++) push(12'(j), 16'h1E20);
        send(8'h78, 8'h1E);
        check("wrap_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
        wait_idle();
        repeat (2) @(negedge clk_sys);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // clear_req and char_valid together
        @(negedge clk_sys);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h51;
        char_attr  = 8'h2A;
        for (int i = 0; i < 3000; i++) push(12'(i), 16'h2A20);
        push(12'd0, 16'h2A51);
        #1 check("clr_req_ready_low", 32'(char_ready), 32'd0);
        @(posedge clk_sys);
        #1 clear_req = 1'b0;
        check("clr_req_busy", 32'(busy), 32'd1);
        n = 0;
        @(negedge clk_sys);
        while (!char_ready && n < 4000) begin
            @(negedge clk_sys);
            n++;
        end
        check("clr_req_ready_back", 32'(char_ready), 32'd1);
        @(posedge clk_sys);
        #1 char_valid = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("clr_req_queue_empty", 32'(exp_q.size()), 32'd0);
        check("clr_req_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd0, 7'd1});

        // CR, BS at col 0, ignored bytes
        send(8'h0D, 8'h34);
        send(8'h08, 8'h34);
        send(8'h01, 8'h34);
        send(8'h7F, 8'h34);
        repeat (3) @(negedge clk_sys);
        check("bs_col0_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);

        // BS after a character
        push(12'd0, 16'h3443);
        push(12'd0, 16'h3420);
        send(8'h43, 8'h34);
        send(8'h08, 8'h34);
        repeat (3) @(negedge clk_sys);
        check("bs_cursor", 32'(cursor_col), 32'd0);

`ifdef TEXT_CONSOLE_TAB_EN
        for (int i = 0; i < 3; i++) begin
            ch = 8'h61 + 8'(i);
            push(12'(i), {8'h34, 1'b0, ch[6:0]});
            send(ch, 8'h34);
        end
        send(8'h09, 8'h34);
        repeat (3) @(negedge clk_sys);
        check("tab_col", 32'(cursor_col), 32'd8);
`else
        send(8'h09, 8'h34);
        repeat (3) @(negedge clk_sys);
        check("tab_ignored_col", 32'(cursor_col), 32'd0);
`endif

        repeat (5) @(negedge clk_sys);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream feeder of the LCD text-mode display. Accepts a byte stream from the CPU side over a valid/ready handshake.
- Interprets printable bytes and a small set of control codes, tracks the cursor, and drives the text RAM write port (ram_ce/ram_addr/ram_data).
- Single clock domain on clk_sys. Text RAM word format: {attr[7:0], 1'b0, char[6:0]}; attr high nibble is foreground, low nibble is background.

Parameters:
- COLS, 100, characters per line.
- ROWS, 30, lines per page.
- BLANK_ATTR, 8'h0F, attribute used by the post-reset screen clear.
- CLEAR_ON_RESET, 1, when 1, a full-screen clear runs after reset release.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- char_valid  in  1  byte available.
- char_data  in  8  byte to process.
- char_attr  in  8  attribute, sampled with the byte.
- char_ready  out  1  block can accept a byte this cycle.
- clear_req  in  1  single-cycle request: clear screen and home the cursor, using char_attr.
- busy  out  1  clear sequence in progress.
- ram_ce  out  1  text RAM write enable.
- ram_addr  out  12  text RAM address.
- ram_data  out  16  text RAM write data.
- cursor_col  out  7  current column.
- cursor_row  out  5  current row.

Behaviour:
- Reset (asynchronous, reset low): all outputs are 0, state is IDLE, cursor is (0,0), line_base is 0. On release with CLEAR_ON_RESET=1, the block enters CLR_SCREEN using BLANK_ATTR.
- States:
  - IDLE: char_ready = (state==IDLE) && !clear_req, combinational.
  - CLR_LINE and CLR_SCREEN: char_ready=0, busy=1.
- Accept: a byte is accepted when char_valid && char_ready. Outputs are registered: the resulting ram_ce pulse appears on the next cycle with ram_addr = line_base + col. Back-to-back accepts are allowed, one per cycle.
- line_base is a running register equal to row*COLS; no multiplier. It steps by +COLS per row and resets to 0 on wrap.
- Byte handling:
  - 0x20..0x7E: write {attr, 0, byte[6:0]} at the cursor, then col+1.
    - If col was COLS-1: col=0, row advances, then CLR_LINE.
  - 0x0A (LF): col=0, row advances, then CLR_LINE.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS): if col>0, col-1 and write a blank {attr,8'h20} there; if col==0, no change.
  - 0x0C (FF): CLR_SCREEN with the byte's attr.
  - All other bytes (0x00..0x1F not listed, 0x7F..0xFF) are consumed and ignored; there is no write.
- Row advance: row+1. If row was ROWS-1, row wraps to 0 and line_base to 0. There is no scrolling.
- CLR_LINE: writes blank {attr,8'h20} to COLS consecutive addresses starting at the new line_base, one per cycle (COLS cycles), then returns to IDLE. The cursor stays at (0,row).
- CLR_SCREEN: writes the blank to addresses 0..COLS*ROWS-1 (3000 cycles), then sets the cursor to (0,0) and returns to IDLE.
- clear_req:
  - In IDLE it has priority over char_valid in the same cycle; the byte is not accepted (char_ready is low).
  - During CLR_LINE, clear_req aborts the line clear and starts CLR_SCREEN.
  - During CLR_SCREEN, clear_req is ignored.
- ram_ce is high exactly one cycle per write. Between writes, ram_addr and ram_data hold their last values.
- Reset asserted mid-clear aborts immediately. After release, the clear restarts from address 0 (when CLEAR_ON_RESET=1).

Optional Feature:
- Macro: TEXT_CONSOLE_TAB_EN.
- Defined: 0x09 (TAB) advances col to the next multiple of 8 with no writes.
  - If that target is at or beyond COLS, it is treated as LF: row advances, then CLR_LINE.
- Undefined: 0x09 is ignored like any other unlisted control code.

Decomposition:
- Package text_console_pkg holds:
  - COLS/ROWS defaults.
  - Control code constants: CH_LF, CH_CR, CH_BS, CH_FF, CH_TAB, CH_SPACE.
  - The state enum: IDLE, CLR_LINE, CLR_SCREEN.
  - A blank-word helper constant.
- One sub-module, text_cursor: holds col/row/line_base with home, col inc/dec, and row advance-with-wrap. The FSM and RAM port driver stay in the top.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 -> 3000 ram_ce pulses, addr 0..2999, data 16'h0F20; char_ready low until done; cursor (0,0).
- Send "AB" with attr 8'h1E, back-to-back -> writes addr 0 data 16'h1E41, addr 1 data 16'h1E42 on consecutive cycles; cursor_col=2.
- Cursor at (5,2), send 0x0A -> cursor (0,3); 100 blank writes at addr 300..399; char_ready low for 100 cycles.
- Cursor at col 99, row 29, send 'x' -> write at addr 2999, cursor wraps to (0,0), line clear at addr 0..99.
- clear_req and char_valid high in the same IDLE cycle -> byte not accepted, CLR_SCREEN runs; byte accepted after busy falls.
- Cursor at col 0, send 0x08 -> no write, cursor unchanged. With TEXT_CONSOLE_TAB_EN, col 3 plus 0x09 -> col 8, no write.
